// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : Load-use stall and registered EX operand forwarding control for
//            the 5-stage MIPS pipeline. Optional HAZARD_STALL_COUNT_EN adds a
//            saturating stall counter output.
// Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_id_valid,
  input  logic [REG_AW-1:0] in_id_rs,
  input  logic [REG_AW-1:0] in_id_rt,
  input  logic              in_id_uses_rs,
  input  logic              in_id_uses_rt,
  input  logic [REG_AW-1:0] in_id_aw,
  input  logic              in_id_reg_write,
  input  logic              in_id_mem_read,
  input  logic              in_flush,
  output logic              out_stall,
  output logic [1:0]        out_fwd_a,
  output logic [1:0]        out_fwd_b,
`ifdef HAZARD_STALL_COUNT_EN
  output logic [CNT_W-1:0]  out_stall_cnt,
`endif
  output logic [REG_AW-1:0] out_ex_aw
);

  localparam logic [1:0] c_fwd_rf  = 2'b00;
  localparam logic [1:0] c_fwd_mem = 2'b01;
  localparam logic [1:0] c_fwd_wb  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] aw;
    logic              reg_write;
    logic              mem_read;
  } entry_t;

  entry_t     r_ex, r_mem, r_wb;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_stall;
  logic       w_load_ex;

  // Nearest producer wins; a load still in EX never forwards (it stalls instead).
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                         input entry_t ex, input entry_t mem);
    if (used && (src != '0) && ex.valid && ex.reg_write && !ex.mem_read && (src == ex.aw))
      return c_fwd_mem;
    else if (used && (src != '0) && mem.valid && mem.reg_write && (src == mem.aw))
      return c_fwd_wb;
    return c_fwd_rf;
  endfunction

  always_comb begin
    w_stall = in_id_valid && !in_flush &&
              r_ex.valid && r_ex.mem_read && r_ex.reg_write && (r_ex.aw != '0) &&
              ((in_id_uses_rs && (in_id_rs == r_ex.aw)) ||
               (in_id_uses_rt && (in_id_rt == r_ex.aw)));
    w_load_ex = in_id_valid && !in_flush && !w_stall;
    w_fwd_a   = fwd_sel(in_id_uses_rs, in_id_rs, r_ex, r_mem);
    w_fwd_b   = fwd_sel(in_id_uses_rt, in_id_rt, r_ex, r_mem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= c_fwd_rf;
      r_fwd_b <= c_fwd_rf;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_load_ex) begin
        r_ex    <= '{1'b1, in_id_aw, in_id_reg_write, in_id_mem_read};
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end else begin
        r_ex    <= '0;
        r_fwd_a <= c_fwd_rf;
        r_fwd_b <= c_fwd_rf;
      end
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_stall_cnt = r_stall_cnt;
`endif

  assign out_stall = w_stall;
  assign out_fwd_a = r_fwd_a;
  assign out_fwd_b = r_fwd_b;
  assign out_ex_aw = r_ex.valid ? r_ex.aw : '0;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Purpose  : Directed self-checking bench for hazard_fwd_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_fwd_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_id_valid;
  logic [REG_AW-1:0] in_id_rs, in_id_rt, in_id_aw;
  logic              in_id_uses_rs, in_id_uses_rt;
  logic              in_id_reg_write, in_id_mem_read, in_flush;
  logic              out_stall;
  logic [1:0]        out_fwd_a, out_fwd_b;
  logic [REG_AW-1:0] out_ex_aw;
`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0]  out_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_id_valid     (in_id_valid),
    .in_id_rs        (in_id_rs),
    .in_id_rt        (in_id_rt),
    .in_id_uses_rs   (in_id_uses_rs),
    .in_id_uses_rt   (in_id_uses_rt),
    .in_id_aw        (in_id_aw),
    .in_id_reg_write (in_id_reg_write),
    .in_id_mem_read  (in_id_mem_read),
    .in_flush        (in_flush),
    .out_stall       (out_stall),
    .out_fwd_a       (out_fwd_a),
    .out_fwd_b       (out_fwd_b),
`ifdef HAZARD_STALL_COUNT_EN
    .out_stall_cnt   (out_stall_cnt),
`endif
    .out_ex_aw       (out_ex_aw)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] aw,
                       input logic rw, input logic mr, input logic fl);
    in_id_valid = v;   in_id_rs = rs;        in_id_rt = rt;
    in_id_uses_rs = urs; in_id_uses_rt = urt; in_id_aw = aw;
    in_id_reg_write = rw; in_id_mem_read = mr; in_flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Returns 1 ns after the rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    #2;
    tick();
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", out_stall); end
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %0b expected 00", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %0b expected 00", out_fwd_b); end
    checks++; if (out_ex_aw !== 5'd0) begin errors++; $display("FAIL reset_ex_aw: got %0d expected 0", out_ex_aw); end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_fwd();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);      // add $3
    tick();
    drive(1, 3, 3, 1, 0, 8, 1, 0, 0);      // sub $8 <- $3, imm (rt unused)
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b expected 0", out_stall); end
    tick();
    idle();
    checks++; if (out_fwd_a !== 2'b01) begin errors++; $display("FAIL alu_fwd_a: got %0b expected 01", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_b: got %0b expected 00", out_fwd_b); end
    checks++; if (out_ex_aw !== 5'd8) begin errors++; $display("FAIL alu_ex_aw: got %0d expected 8", out_ex_aw); end
    tick();
  endtask

  task automatic test_distance2();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);      // add $5
    tick();
    idle();                                // nop
    tick();
    drive(1, 1, 5, 1, 1, 10, 1, 0, 0);     // or $10 <- $1, $5
    tick();
    idle();
    checks++; if (out_fwd_b !== 2'b10) begin errors++; $display("FAIL dist2_fwd_b: got %0b expected 10", out_fwd_b); end
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL dist2_fwd_a: got %0b expected 00", out_fwd_a); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);      // lw $7
    tick();
    drive(1, 7, 2, 1, 1, 9, 1, 0, 0);      // add $9 <- $7, $2
    #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %0b expected 1", out_stall); end
    tick();
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %0b expected 0", out_stall); end
    checks++; if (out_ex_aw !== 5'd0) begin errors++; $display("FAIL lu_bubble_aw: got %0d expected 0", out_ex_aw); end
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd_a: got %0b expected 00", out_fwd_a); end
    tick();
    idle();
    checks++; if (out_fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %0b expected 10", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %0b expected 00", out_fwd_b); end
    checks++; if (out_ex_aw !== 5'd9) begin errors++; $display("FAIL lu_ex_aw: got %0d expected 9", out_ex_aw); end
`ifdef HAZARD_STALL_COUNT_EN
    checks++; if (out_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", out_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_reg_zero();
    idle();
    tick();
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);      // ALU writing $0
    tick();
    drive(1, 0, 0, 1, 1, 11, 1, 0, 0);     // consumer of $0, $0
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL r0_alu_stall: got %0b expected 0", out_stall); end
    tick();
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL r0_alu_fwd_a: got %0b expected 00", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'b00) begin errors++; $display("FAIL r0_alu_fwd_b: got %0b expected 00", out_fwd_b); end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);      // lw $0
    tick();
    drive(1, 0, 0, 1, 1, 11, 1, 0, 0);
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL r0_load_stall: got %0b expected 0", out_stall); end
    tick();
    idle();
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL r0_load_fwd_a: got %0b expected 00", out_fwd_a); end
    checks++; if (out_ex_aw !== 5'd11) begin errors++; $display("FAIL r0_load_ex_aw: got %0d expected 11", out_ex_aw); end
    tick();
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);      // add $4
    tick();
    drive(1, 6, 0, 1, 0, 4, 1, 0, 0);      // add $4 <- $6
    tick();
    drive(1, 4, 4, 1, 1, 12, 1, 0, 0);     // consumer of $4, $4
    tick();
    idle();
    checks++; if (out_fwd_a !== 2'b01) begin errors++; $display("FAIL prio_fwd_a: got %0b expected 01", out_fwd_a); end
    checks++; if (out_fwd_b !== 2'b01) begin errors++; $display("FAIL prio_fwd_b: got %0b expected 01", out_fwd_b); end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);      // lw $7
    tick();
    drive(1, 7, 0, 1, 0, 9, 1, 0, 1);      // dependent add, killed by flush
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b expected 0", out_stall); end
    tick();
    idle();
    checks++; if (out_ex_aw !== 5'd0) begin errors++; $display("FAIL flush_ex_aw: got %0d expected 0", out_ex_aw); end
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a: got %0b expected 00", out_fwd_a); end
`ifdef HAZARD_STALL_COUNT_EN
    checks++; if (out_stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected 1", out_stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(1, 3, 0, 1, 0, 8, 1, 0, 0);
    tick();
    idle();
    checks++; if (out_fwd_a !== 2'b01) begin errors++; $display("FAIL areset_pre_fwd_a: got %0b expected 01", out_fwd_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_fwd_a !== 2'b00) begin errors++; $display("FAIL areset_fwd_a: got %0b expected 00", out_fwd_a); end
    checks++; if (out_ex_aw !== 5'd0) begin errors++; $display("FAIL areset_ex_aw: got %0d expected 0", out_ex_aw); end
`ifdef HAZARD_STALL_COUNT_EN
    checks++; if (out_stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_stall_cnt: got %0d expected 0", out_stall_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_distance2();
    test_load_use();
    test_reg_zero();
    test_priority();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Sequences the EX-stage operand selection that sits ahead of the ALU-source mux.
- Tracks the destination register produced by the rt/rd destination mux for each instruction in EX, MEM and WB, using an internal shadow pipeline.
- Issues load-use stalls and registered forwarding selects for both ALU operands.
- Sits beside the ID/EX pipeline register and is driven by the decoder.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall counter width (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_id_valid  input  1  ID stage holds a real instruction.
- in_id_rs  input  REG_AW  source register A of the ID instruction.
- in_id_rt  input  REG_AW  source register B of the ID instruction.
- in_id_uses_rs  input  1  ID instruction reads rs.
- in_id_uses_rt  input  1  ID instruction reads rt; 0 when the immediate is selected and rt is not a store source.
- in_id_aw  input  REG_AW  destination register output by the rt/rd destination mux.
- in_id_reg_write  input  1  ID instruction writes the register file.
- in_id_mem_read  input  1  ID instruction is a load.
- in_flush  input  1  branch or jump taken; kill the ID instruction.
- out_stall  output  1  hold PC and IF/ID, insert a bubble into EX.
- out_fwd_a  output  2  EX operand A select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- out_fwd_b  output  2  EX operand B select, same encoding; feeds the dr2 input of the ALU-source mux.
- out_ex_aw  output  REG_AW  destination register of the instruction currently in EX.

Behaviour:
- Shadow entries ex, mem, wb. Each entry holds {valid, aw, reg_write, mem_read}.
- Reset: all entries invalid with zero fields. out_fwd_a and out_fwd_b = 00. out_ex_aw = 0. out_stall = 0, because there are no valid entries.
- out_stall is combinational. It is 1 when all of the following hold:
  - in_id_valid = 1 and in_flush = 0;
  - ex.valid, ex.mem_read and ex.reg_write are all 1, and ex.aw != 0;
  - (in_id_uses_rs = 1 and in_id_rs == ex.aw) or (in_id_uses_rt = 1 and in_id_rt == ex.aw).
- Each rising edge: wb <= mem and mem <= ex.
- ex <= ID fields with valid = in_id_valid & ~in_flush & ~out_stall. Otherwise ex becomes a bubble with all fields zeroed.
- Forward-select computation, per operand, for the ID instruction:
  - if the operand is used, its register is != 0, ex.valid = 1, ex.reg_write = 1, ex.mem_read = 0 and the register matches ex.aw: 01;
  - else if the operand is used, its register is != 0, mem.valid = 1, mem.reg_write = 1 and the register matches mem.aw: 10;
  - else 00.
  - The nearest producer always wins.
- The computed selects are registered into out_fwd_a/out_fwd_b on the same edge that loads ex. A bubble loads 00.
- Latency: selects are valid in the cycle the instruction occupies EX, i.e. one cycle after ID.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in mem and the dependent instruction takes select 10.
- Register 0 is never forwarded and never causes a stall.
- Flush and stall in the same cycle: flush wins. out_stall = 0 and a bubble enters ex.
- Stall with in_id_valid = 0 cannot occur; out_stall = 0.
- Asserting rst_n low mid-operation clears every entry immediately. Outputs return to their reset values without waiting for a clock edge.
- out_ex_aw = ex.aw when ex.valid = 1, else 0.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- With the macro defined:
  - adds output out_stall_cnt, width CNT_W;
  - reset value 0;
  - increments on every rising edge where out_stall = 1;
  - saturates at all ones and does not wrap.
- Without the macro: the port and the counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset: drive rst_n = 0 with random inputs -> out_stall = 0, out_fwd_a = 00, out_fwd_b = 00, out_ex_aw = 0.
- ALU-ALU forwarding: add $3 (aw = 3, reg_write = 1), then sub using rs = 3 -> in the sub's EX cycle out_fwd_a = 01, out_fwd_b = 00, no stall.
- Distance 2: add $5, then nop, then or using rt = 5 -> out_fwd_b = 10 in the or's EX cycle.
- Load-use: lw $7 (mem_read = 1), then add using rs = 7 -> out_stall = 1 for exactly one cycle, then out_fwd_a = 10 and out_stall = 0. With HAZARD_STALL_COUNT_EN, out_stall_cnt = 1.
- Register zero and priority:
  - producer aw = 0 -> selects 00, no stall;
  - two producers both writing $4 in EX and MEM -> select 01 (nearest wins).
- Flush during a load-use condition: in_flush = 1 -> out_stall = 0, ex becomes a bubble, next out_fwd_a = 00 and out_ex_aw = 0.
